// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract, one SLICE-bit ripple-carry slice per pipeline stage.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   Number1_i/Number2_i operands A and B
//   Carry_i, Sub_i      carry-in; Sub_i=1 adds ~B instead of B
//   Valid_i, Ready_o    upstream handshake, Ready_o = Ready_i | ~Valid_o
//   Result_o, Carry_o   registered sum/difference and MSB carry-out
//   Overflow_o, Zero_o  registered signed-overflow and zero flags
//   Valid_o, Ready_i    downstream handshake; a stall freezes the whole pipeline
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    input  logic             Sub_i,
    input  logic             Valid_i,
    output logic             Ready_o,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o,
    output logic             Overflow_o,
    output logic             Zero_o,
    output logic             Valid_o,
    input  logic             Ready_i
);
    localparam int SLICE = WIDTH / STAGES;

    logic             adv;
    // Inputs seen by stage k: operands delayed k cycles, lower result slices already done.
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             c_s [STAGES];
    logic             v_s [STAGES];
    // Combinational outputs of stage k.
    logic [WIDTH-1:0] r_d [STAGES];
    logic             c_d [STAGES];
    logic             cm_d;

    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             valid_q;

    assign adv     = Ready_i | ~valid_q;
    assign Ready_o = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic [SLICE:0]   cc;
        logic [WIDTH-1:0] r_loc;
        always_comb begin
            r_loc = r_s[k];
            cc    = {{SLICE{1'b0}}, c_s[k]};
            for (int i = 0; i < SLICE; i++) begin
                r_loc[k*SLICE+i] = a_s[k][k*SLICE+i] ^ b_s[k][k*SLICE+i] ^ cc[i];
                cc[i+1] = (a_s[k][k*SLICE+i] & b_s[k][k*SLICE+i])
                        | (cc[i] & (a_s[k][k*SLICE+i] ^ b_s[k][k*SLICE+i]));
            end
        end
        assign r_d[k] = r_loc;
        assign c_d[k] = cc[SLICE];

        // Carry into the MSB drives the overflow flag.
        if (k == STAGES - 1) begin : g_msb
            assign cm_d = cc[SLICE-1];
        end

        if (k == 0) begin : g_in
            // Subtract mode is folded into B here, so it travels with the operands.
            assign a_s[0] = Number1_i;
            assign b_s[0] = Sub_i ? ~Number2_i : Number2_i;
            assign r_s[0] = '0;
            assign c_s[0] = Carry_i;
            assign v_s[0] = Valid_i;
        end else begin : g_in
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] r_q;
            logic             c_q;
            logic             v_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                    r_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (adv) begin
                    a_q <= a_s[k-1];
                    b_q <= b_s[k-1];
                    r_q <= r_d[k-1];
                    c_q <= c_d[k-1];
                    v_q <= v_s[k-1];
                end
            end
            assign a_s[k] = a_q;
            assign b_s[k] = b_q;
            assign r_s[k] = r_q;
            assign c_s[k] = c_q;
            assign v_s[k] = v_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else if (adv) begin
            result_q <= r_d[STAGES-1];
            carry_q  <= c_d[STAGES-1];
            ovf_q    <= c_d[STAGES-1] ^ cm_d;
            zero_q   <= ~|r_d[STAGES-1];
            valid_q  <= v_s[STAGES-1];
        end
    end

    assign Result_o   = result_q;
    assign Carry_o    = carry_q;
    assign Overflow_o = ovf_q;
    assign Zero_o     = zero_q;
    assign Valid_o    = valid_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: checks pipelined_adder at STAGES=4 (main, with backpressure) and 1/2/8/32 (sweep).
module tb_pipelined_adder;
    localparam int N = 5;

    function automatic int stg(int g);
        return g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 2 : g == 3 ? 8 : 32;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        vld = 1'b0;
    logic        rdy = 1'b1;
    logic        rdo [N];
    logic [31:0] ro  [N];
    logic        co  [N];
    logic        oo  [N];
    logic        zo  [N];
    logic        vo  [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        pipelined_adder #(.WIDTH(32), .STAGES(stg(g))) u_dut (
            .clk(clk), .rst(rst), .Number1_i(a), .Number2_i(b), .Carry_i(cin), .Sub_i(sub),
            .Valid_i(vld), .Ready_o(rdo[g]), .Result_o(ro[g]), .Carry_o(co[g]),
            .Overflow_o(oo[g]), .Zero_o(zo[g]), .Valid_o(vo[g]), .Ready_i(g == 0 ? rdy : 1'b1)
        );
    end

    typedef struct packed { logic [31:0] r; logic c; logic o; logic z; } res_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic ci; logic s; res_t e; } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    res_t exp_q [N][$];
    int   t_q   [N][$];

    // Reference: plain wide arithmetic on the operands, flags from the sign rule.
    function automatic res_t model(logic [31:0] x, logic [31:0] y, logic ci, logic s);
        logic [31:0] yy;
        logic [32:0] full;
        res_t m;
        yy   = s ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
        m.r  = full[31:0];
        m.c  = full[32];
        m.o  = (x[31] == yy[31]) && (m.r[31] != x[31]);
        m.z  = (m.r == 32'd0);
        return m;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on transfer in, pop and compare on transfer out, check stalls hold.
    logic        stalled = 1'b0;
    logic [35:0] hold;
    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < N; g++) begin
                exp_q[g].delete();
                t_q[g].delete();
            end
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {28'd0, ro[0], co[0], oo[0], zo[0], vo[0]}, {28'd0, hold});
            chk("ready_o", {63'd0, rdo[0]}, {63'd0, !vo[0] || rdy});
            for (int g = 0; g < N; g++) begin
                if (vo[g] && (g != 0 || rdy)) begin
                    if (exp_q[g].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL spurious_out s%0d: got result %h, required no valid output", stg(g), ro[g]);
                    end else begin
                        res_t e;
                        int t;
                        e = exp_q[g].pop_front();
                        t = t_q[g].pop_front();
                        chk($sformatf("result_s%0d", stg(g)), {29'd0, ro[g], co[g], oo[g], zo[g]}, {29'd0, e});
                        if (g != 0) chk($sformatf("latency_s%0d", stg(g)), 64'(cyc), 64'(t));
                    end
                end
                if (vld && rdo[g]) begin
                    exp_q[g].push_back(model(a, b, cin, sub));
                    t_q[g].push_back(cyc + stg(g));
                end
            end
            stalled = vo[0] && !rdy;
            hold    = {ro[0], co[0], oo[0], zo[0], vo[0]};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t tv [8];
    int   lat;
    int   first;
    int   last;
    int   cnt;
    logic stall_done;

    initial begin
        tv[0] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0, 1'b1}};
        tv[1] = '{32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 1'b0}};
        tv[2] = '{32'd5,         32'd7, 1'b1, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}};
        tv[3] = '{32'd7,         32'd5, 1'b1, 1'b1, '{32'h0000_0002, 1'b1, 1'b0, 1'b0}};
        tv[4] = '{32'd0,         32'd0, 1'b0, 1'b0, '{32'h0000_0000, 1'b0, 1'b0, 1'b1}};
        tv[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1, 1'b1}};
        tv[6] = '{32'h8000_0000, 32'd1, 1'b1, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        tv[7] = '{32'h1234_5678, 32'h0000_FFFF, 1'b1, 1'b0, '{32'h1235_5678, 1'b0, 1'b0, 1'b0}};

        // Reset state.
        repeat (2) step();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("reset_valid_s%0d", stg(g)), {63'd0, vo[g]}, 64'd0);
            chk($sformatf("reset_out_s%0d", stg(g)), {29'd0, ro[g], co[g], oo[g], zo[g]}, 64'd0);
        end
        rst = 1'b0;
        step();

        // Directed vectors, one at a time, with latency.
        for (int i = 0; i < 8; i++) begin
            a = tv[i].a; b = tv[i].b; cin = tv[i].ci; sub = tv[i].s; vld = 1'b1;
            step();
            vld = 1'b0;
            lat = 1;
            while (!vo[0] && lat < 20) begin
                step();
                lat++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d", i), {29'd0, ro[0], co[0], oo[0], zo[0]}, {29'd0, tv[i].e});
        end
        repeat (4) step();

        // Back-to-back stream of 8.
        first = 0; last = 0; cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); vld = (c <= 8);
            step();
            if (vo[0]) begin
                if (first == 0) first = c;
                last = c;
                cnt++;
            end
        end
        vld = 1'b0;
        chk("b2b_first", 64'(first), 64'd4);
        chk("b2b_count", 64'(cnt), 64'd8);
        chk("b2b_last", 64'(last), 64'd11);

        // Backpressure: 5-cycle stall once the first result shows.
        stall_done = 1'b0;
        for (int c = 0; c < 30; c++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); vld = (c < 12);
            step();
            if (vo[0] && !stall_done) begin
                rdy = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    step();
                    chk("bp_ready_o", {63'd0, rdo[0]}, 64'd0);
                end
                rdy = 1'b1;
                stall_done = 1'b1;
            end
        end
        vld = 1'b0;
        chk("bp_stall_seen", {63'd0, stall_done}, 64'd1);
        repeat (20) step();
        chk("bp_drained", 64'(exp_q[0].size()), 64'd0);

        // Reset with 3 operations in flight.
        for (int c = 0; c < 3; c++) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom); vld = 1'b1;
            step();
        end
        vld = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int g = 0; g < N; g++) begin
            chk($sformatf("midrst_valid_s%0d", stg(g)), {63'd0, vo[g]}, 64'd0);
            chk($sformatf("midrst_out_s%0d", stg(g)), {29'd0, ro[g], co[g], oo[g], zo[g]}, 64'd0);
        end
        cnt = 0;
        repeat (40) begin
            step();
            if (vo[0]) cnt++;
        end
        chk("midrst_no_ghost", 64'(cnt), 64'd0);

        // Random traffic with random backpressure on the main instance.
        repeat (600) begin
            a = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF) : $urandom;
            b = ($urandom_range(3) == 0) ? (($urandom_range(1) == 0) ? 32'h8000_0000 : 32'd1) : $urandom;
            cin = 1'($urandom);
            sub = 1'($urandom);
            vld = ($urandom_range(9) < 7);
            rdy = ($urandom_range(9) < 7);
            step();
        end
        vld = 1'b0;
        rdy = 1'b1;
        repeat (50) step();
        for (int g = 0; g < N; g++)
            chk($sformatf("drain_s%0d", stg(g)), 64'(exp_q[g].size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's combinational ripple-carry adder.
- Operands are split into STAGES equal slices. Each pipeline stage ripples one slice and registers its carry into the next stage.
- Adds add/subtract mode, signed-overflow and zero flags, and a valid/ready handshake with full-pipeline backpressure.
- Sits between operand producers (ALU/MAC datapaths) and result consumers that may stall.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); SLICE = WIDTH/STAGES bits ripple per stage.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Number1_i  input  WIDTH  operand A.
- Number2_i  input  WIDTH  operand B.
- Carry_i  input  1  carry-in.
- Sub_i  input  1  0: A+B+Carry_i; 1: A+~B+Carry_i (drive Carry_i=1 for plain A-B).
- Valid_i  input  1  operands valid this cycle.
- Ready_o  output  1  block accepts operands this cycle.
- Result_o  output  WIDTH  sum/difference.
- Carry_o  output  1  carry-out of the MSB (for subtraction, 1 means no borrow).
- Overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- Zero_o  output  1  Result_o == 0.
- Valid_o  output  1  result outputs valid.
- Ready_i  input  1  downstream accepts the result.

Behaviour:
- Reset (rst=1 at a rising edge): all stage valid bits cleared, so Valid_o=0. Result_o, Carry_o, Overflow_o and Zero_o reset to 0. All skew and carry registers reset to 0. Reset overrides everything, including mid-flight data; in-flight results are discarded and never emerge.
- Advance condition: adv = Ready_i | ~Valid_o.
  - Ready_o = adv, combinational.
  - Transfer in: Valid_i & Ready_o. Transfer out: Valid_o & Ready_i.
- Stage k (0..STAGES-1) adds slice k: bits [k*SLICE +: SLICE] of A and of (Sub_i ? ~B : B), delayed k cycles.
  - Carry-in of stage 0 is Carry_i; carry-in of stage k>0 is the registered carry-out of stage k-1.
  - Lower result slices are delayed (de-skew registers) so all slices of one operation appear together.
- Sub_i is captured with the operands and travels with them; mode may change every cycle.
- Latency: exactly STAGES cycles from accepted input to Valid_o=1, absent stalls. Throughput is one result per cycle.
- Stall: when adv=0, every pipeline register (data, carries, valids, flags) holds. Outputs stay stable until the transfer out completes.
- Bubbles: Valid_i=0 with adv=1 inserts an invalid slot. Bubbles do not collapse; stall is global.
- Flags are computed in the final stage and registered with Result_o.
  - Overflow_o uses the MSB carry-in/carry-out.
  - Zero_o is the OR-reduction of the full result, inverted.
- Output data when Valid_o=0 is don't-care to consumers, but must not be X after reset.
- Wrap-around: results are modulo 2^WIDTH; carry is reported on Carry_o.
- Simultaneous transfer in and transfer out in one cycle is legal and required at full throughput.
- STAGES=1 degenerates to one registered ripple-carry adder with 1-cycle latency.

Test Plan:
- Defaults; A=32'hFFFF_FFFF, B=1, Cin=0, Sub=0, Ready_i=1 -> 4 cycles later Result=0, Carry=1, Zero=1, Overflow=0.
- A=32'h7FFF_FFFF, B=1, Cin=0, Sub=0 -> Result=32'h8000_0000, Carry=0, Overflow=1, Zero=0.
- Subtraction: A=5, B=7, Cin=1, Sub=1 -> Result=32'hFFFF_FFFE, Carry=0 (borrow), Overflow=0. Then A=7, B=5 -> Result=2, Carry=1.
- Back-to-back stream: 8 operand pairs on consecutive cycles, Ready_i=1 -> 8 consecutive Valid_o cycles, results in order, first result 4 cycles after first input.
- Backpressure: Ready_i=0 for 5 cycles once Valid_o=1 -> Ready_o=0 and outputs frozen. Ready_i=1 -> stream resumes with no loss or duplication.
- Reset mid-flight: assert rst with 3 operations in the pipeline -> next cycle Valid_o=0, outputs 0. None of the 3 results appear afterwards.
- Parameter sweep: STAGES=1, 2, 8, 32 at WIDTH=32 -> results match a behavioural A+B+Cin model; latency equals STAGES.
